// File: rtl/wake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wake_pkg
// Description : Shared types and defaults for the wake-event qualifier:
//               FSM state encoding, default parameter values and a small
//               constant helper for sizing the hold/cooldown timer.
// Revision    : 1.0 - initial release
// ============================================================================
package wake_pkg;

    // Qualifier state encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONFIRM  = 2'd1,
        ST_HOLD     = 2'd2,
        ST_COOLDOWN = 2'd3
    } wake_state_e;

    localparam int CONFIRM_N_DEF       = 2;
    localparam int HOLD_CYCLES_DEF     = 16;
    localparam int COOLDOWN_CYCLES_DEF = 64;
    localparam int COUNT_BW_DEF        = 16;

    // Larger of two integers, used when sizing the shared timer
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wake_irq_if.sv
`default_nettype none
// ============================================================================
// Module      : wake_irq_if
// Description : Decision inputs, control inputs and status outputs of the
//               wake-event qualifier. The master side drives decisions and
//               control, the slave side (the qualifier) drives status.
// Revision    : 1.0 - initial release
// ============================================================================
interface wake_irq_if #(
    parameter int COUNT_BW = wake_pkg::COUNT_BW_DEF
);
    logic                ctl_pipeline_en_i;
    logic                wrd_wake_i;
    logic                wrd_wake_valid_i;
    logic                clear_i;
    logic                wake_o;
    logic                irq_o;
    logic                busy_o;
    logic [COUNT_BW-1:0] wake_count_o;
    logic [COUNT_BW-1:0] decision_count_o;

    modport master (
        output ctl_pipeline_en_i,
        output wrd_wake_i,
        output wrd_wake_valid_i,
        output clear_i,
        input  wake_o,
        input  irq_o,
        input  busy_o,
        input  wake_count_o,
        input  decision_count_o
    );

    modport slave (
        input  ctl_pipeline_en_i,
        input  wrd_wake_i,
        input  wrd_wake_valid_i,
        input  clear_i,
        output wake_o,
        output irq_o,
        output busy_o,
        output wake_count_o,
        output decision_count_o
    );
endinterface
`default_nettype wire

// File: rtl/wake_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : wake_sat_counter
// Description : Saturating up-counter with synchronous clear. A clear and an
//               increment in the same cycle leave the count at one.
// Revision    : 1.0 - initial release
// ============================================================================
module wake_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    // Clear first, then increment; stop at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= i_inc ? WIDTH'(1) : '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/wake_irq.sv
`default_nettype none
// ============================================================================
// Module      : wake_irq
// Description : Wake-event qualifier. Requires CONFIRM_N consecutive positive
//               decisions, then drives a HOLD_CYCLES wake pulse, sets a sticky
//               interrupt and ignores decisions for COOLDOWN_CYCLES.
//               Build option WAKE_IRQ_STATS_EN adds saturating fire/decision
//               counters; without it both count outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wake_irq
    import wake_pkg::*;
#(
    parameter int CONFIRM_N       = CONFIRM_N_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
    parameter int COUNT_BW        = COUNT_BW_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    wake_irq_if.slave  bus
);
    localparam int RUN_W = $clog2(CONFIRM_N + 1);
    localparam int TMR_W = $clog2(max_int(HOLD_CYCLES, COOLDOWN_CYCLES) + 1);

    localparam logic [RUN_W-1:0] c_confirm   = RUN_W'(CONFIRM_N);
    localparam logic [TMR_W-1:0] c_hold_last = TMR_W'(HOLD_CYCLES - 1);
    // Unused when there is no cooldown; kept in range so it never goes negative
    localparam logic [TMR_W-1:0] c_cool_last =
        TMR_W'((COOLDOWN_CYCLES > 0) ? (COOLDOWN_CYCLES - 1) : 0);

    wake_state_e      r_state;
    logic [RUN_W-1:0] r_run;
    logic [TMR_W-1:0] r_timer;
    logic             r_wake;
    logic             r_busy;
    logic             r_irq;

    logic             w_en;
    logic             w_pos;
    logic             w_neg;
    logic [RUN_W-1:0] w_run_inc;
    logic             w_fire;

    assign w_en      = bus.ctl_pipeline_en_i;
    assign w_pos     = w_en && bus.wrd_wake_valid_i && bus.wrd_wake_i;
    assign w_neg     = w_en && bus.wrd_wake_valid_i && !bus.wrd_wake_i;
    assign w_run_inc = r_run + RUN_W'(1);

    // A fire is the transition into HOLD: the decision that completes the run
    assign w_fire = w_pos &&
                    (((r_state == ST_IDLE) && (CONFIRM_N == 1)) ||
                     ((r_state == ST_CONFIRM) && (w_run_inc == c_confirm)));

    // Qualifier FSM with run counter, shared hold/cooldown timer and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_en) begin
            r_state <= ST_IDLE;
            r_run   <= '0;
            r_timer <= '0;
            r_wake  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (w_fire) begin
            r_state <= ST_HOLD;
            r_run   <= '0;
            r_timer <= '0;
            r_wake  <= 1'b1;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pos) begin
                        r_state <= ST_CONFIRM;
                        r_run   <= RUN_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (w_pos) begin
                        r_run <= w_run_inc;
                    end else if (w_neg) begin
                        r_state <= ST_IDLE;
                        r_run   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (r_timer == c_hold_last) begin
                        r_timer <= '0;
                        r_wake  <= 1'b0;
                        if (COOLDOWN_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_COOLDOWN;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_COOLDOWN: begin
                    if (r_timer == c_cool_last) begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_run   <= '0;
                    r_timer <= '0;
                    r_wake  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky interrupt: a fire wins over a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else if (w_fire) begin
            r_irq <= 1'b1;
        end else if (bus.clear_i) begin
            r_irq <= 1'b0;
        end
    end

    assign bus.wake_o = r_wake;
    assign bus.irq_o  = r_irq;
    assign bus.busy_o = r_busy;

`ifdef WAKE_IRQ_STATS_EN
    logic                w_dec_inc;
    logic [COUNT_BW-1:0] w_wake_count;
    logic [COUNT_BW-1:0] w_dec_count;

    assign w_dec_inc = w_en && bus.wrd_wake_valid_i;

    wake_sat_counter #(
        .WIDTH (COUNT_BW)
    ) u_wake_cnt (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_clear (bus.clear_i),
        .i_inc   (w_fire),
        .o_count (w_wake_count)
    );

    wake_sat_counter #(
        .WIDTH (COUNT_BW)
    ) u_dec_cnt (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_clear (bus.clear_i),
        .i_inc   (w_dec_inc),
        .o_count (w_dec_count)
    );

    assign bus.wake_count_o     = w_wake_count;
    assign bus.decision_count_o = w_dec_count;
`else
    assign bus.wake_count_o     = '0;
    assign bus.decision_count_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wake_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wake_irq
// Description : Directed bench for wake_irq. Instance A uses default
//               parameters; instance B uses COUNT_BW=2, HOLD_CYCLES=1,
//               COOLDOWN_CYCLES=0 to reach counter saturation quickly.
//               Expected counts follow WAKE_IRQ_STATS_EN (zero when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wake_irq;

`ifdef WAKE_IRQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wake_irq_if #(.COUNT_BW(16)) a_if ();
    wake_irq_if #(.COUNT_BW(2))  b_if ();

    wake_irq #(
        .CONFIRM_N       (2),
        .HOLD_CYCLES     (16),
        .COOLDOWN_CYCLES (64),
        .COUNT_BW        (16)
    ) u_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (a_if.slave)
    );

    wake_irq #(
        .CONFIRM_N       (2),
        .HOLD_CYCLES     (1),
        .COOLDOWN_CYCLES (0),
        .COUNT_BW        (2)
    ) u_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b_if.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model state
    int  a_wc = 0, a_dc = 0, b_wc = 0, b_dc = 0;
    bit  a_en = 1'b1;

    function automatic int cnt_exp(input int v, input int maxv);
        if (!STATS) return 0;
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic push(input string tag, input logic [31:0] e);
        sb_t s;
        s.tag = tag;
        s.exp = e;
        sb_q.push_back(s);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t s;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%0h expected=<none>", obs);
        end else begin
            s = sb_q.pop_front();
            assert (obs === s.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", s.tag, obs, s.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic w, input logic c);
        a_if.wrd_wake_valid_i = v;
        a_if.wrd_wake_i       = w;
        a_if.clear_i          = c;
        if (c) a_dc = 0;
        if (v && a_en) a_dc++;
        tick();
        a_if.wrd_wake_valid_i = 1'b0;
        a_if.wrd_wake_i       = 1'b0;
        a_if.clear_i          = 1'b0;
    endtask

    task automatic drive_b(input logic v, input logic w);
        b_if.wrd_wake_valid_i = v;
        b_if.wrd_wake_i       = w;
        if (v) b_dc++;
        tick();
        b_if.wrd_wake_valid_i = 1'b0;
        b_if.wrd_wake_i       = 1'b0;
    endtask

    task automatic check_a(input logic w, input logic irq, input logic busy);
        push("a_wake", {31'd0, w});
        push("a_irq", {31'd0, irq});
        push("a_busy", {31'd0, busy});
        push("a_wake_count", cnt_exp(a_wc, 65535));
        push("a_dec_count", cnt_exp(a_dc, 65535));
        check({31'd0, a_if.wake_o});
        check({31'd0, a_if.irq_o});
        check({31'd0, a_if.busy_o});
        check({16'd0, a_if.wake_count_o});
        check({16'd0, a_if.decision_count_o});
    endtask

    task automatic check_b(input logic w, input logic irq, input logic busy);
        push("b_wake", {31'd0, w});
        push("b_irq", {31'd0, irq});
        push("b_busy", {31'd0, busy});
        push("b_wake_count", cnt_exp(b_wc, 3));
        push("b_dec_count", cnt_exp(b_dc, 3));
        check({31'd0, b_if.wake_o});
        check({31'd0, b_if.irq_o});
        check({31'd0, b_if.busy_o});
        check({30'd0, b_if.wake_count_o});
        check({30'd0, b_if.decision_count_o});
    endtask

    initial begin
        a_if.ctl_pipeline_en_i = 1'b1;
        a_if.wrd_wake_i        = 1'b0;
        a_if.wrd_wake_valid_i  = 1'b0;
        a_if.clear_i           = 1'b0;
        b_if.ctl_pipeline_en_i = 1'b1;
        b_if.wrd_wake_i        = 1'b0;
        b_if.wrd_wake_valid_i  = 1'b0;
        b_if.clear_i           = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_a(1'b0, 1'b0, 1'b0);
        check_b(1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Two positive decisions ten cycles apart fire on the second one
        repeat (9) tick();
        drive_a(1'b1, 1'b1, 1'b0);
        push("a_wake_confirm", 32'd0);
        check({31'd0, a_if.wake_o});
        repeat (9) tick();
        drive_a(1'b1, 1'b1, 1'b0);
        a_wc++;
        check_a(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 80; k++) begin
            tick();
            push("a_wake_window", (k <= 15) ? 32'd1 : 32'd0);
            push("a_busy_window", (k <= 79) ? 32'd1 : 32'd0);
            check({31'd0, a_if.wake_o});
            check({31'd0, a_if.busy_o});
        end
        check_a(1'b0, 1'b1, 1'b0);

        // Pattern 1,0,1,1 fires only on the fourth decision
        drive_a(1'b1, 1'b1, 1'b0);
        check_a(1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0);
        check_a(1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        check_a(1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        a_wc++;
        check_a(1'b1, 1'b1, 1'b1);
        repeat (80) tick();
        check_a(1'b0, 1'b1, 1'b0);

        // Decisions during HOLD/COOLDOWN are counted but never fire
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        a_wc++;
        check_a(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, 1'b1, 1'b0);
            repeat (7) tick();
        end
        check_a(1'b0, 1'b1, 1'b1);
        repeat (32) tick();
        check_a(1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        a_wc++;
        check_a(1'b1, 1'b1, 1'b1);
        repeat (80) tick();

        // Clear together with a completing decision: the fire wins
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1);
        a_wc = 1;
        check_a(1'b1, 1'b1, 1'b1);
        repeat (20) tick();
        drive_a(1'b0, 1'b0, 1'b1);
        a_wc = 0;
        check_a(1'b0, 1'b0, 1'b1);
        repeat (60) tick();
        check_a(1'b0, 1'b0, 1'b0);

        // Pipeline disable truncates HOLD and ignores decisions
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        a_wc++;
        check_a(1'b1, 1'b1, 1'b1);
        repeat (4) tick();
        check_a(1'b1, 1'b1, 1'b1);
        a_if.ctl_pipeline_en_i = 1'b0;
        a_en = 1'b0;
        tick();
        check_a(1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        check_a(1'b0, 1'b1, 1'b0);
        a_if.ctl_pipeline_en_i = 1'b1;
        a_en = 1'b1;
        drive_a(1'b1, 1'b1, 1'b0);
        check_a(1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        a_wc++;
        check_a(1'b1, 1'b1, 1'b1);
        repeat (80) tick();

        // Reset in the middle of HOLD
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        a_wc++;
        check_a(1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        a_wc = 0;
        a_dc = 0;
        check_a(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Narrow counters saturate at 3 after five fires
        for (int f = 0; f < 5; f++) begin
            drive_b(1'b1, 1'b1);
            drive_b(1'b1, 1'b1);
            b_wc++;
            check_b(1'b1, 1'b1, 1'b1);
            tick();
            check_b(1'b0, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wake_irq.md
# wake_irq

Wake-event qualifier at the end of the keyword-spotting pipeline, directly downstream of the debug mux on the word-detector outputs. It takes per-window wake decisions, requires a run of consecutive positive decisions before waking, then drives a fixed-length wake pulse, a sticky interrupt and a cooldown window. Optional statistics counters are exposed to the management side for bring-up and characterisation.

## Interface
Parameters:
- CONFIRM_N, 2: consecutive positive valid decisions required to fire; legal range ≥1.
- HOLD_CYCLES, 16: cycles wake_o stays high per event; ≥1.
- COOLDOWN_CYCLES, 64: cycles after hold during which decisions are ignored; ≥0.
- COUNT_BW, 16: width of statistics counters.

Ports (one clock; reset is synchronous and active-high):
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous active-high reset.
- ctl_pipeline_en_i  input  1  pipeline enable; low forces IDLE.
- wrd_wake_i  input  1  wake decision, qualified by valid.
- wrd_wake_valid_i  input  1  single-cycle decision strobe.
- clear_i  input  1  clears irq_o and statistics counters.
- wake_o  output  1  wake pulse, HOLD_CYCLES long.
- irq_o  output  1  sticky interrupt, set on each fire.
- busy_o  output  1  high in HOLD or COOLDOWN.
- wake_count_o  output  COUNT_BW  number of fires, saturating.
- decision_count_o  output  COUNT_BW  number of valid strobes seen while enabled, saturating.

## Operation
- States: IDLE, CONFIRM, HOLD, COOLDOWN.
- IDLE: valid with wake=1 → run=1; if CONFIRM_N==1 go HOLD, else CONFIRM. Valid with wake=0 → stay.
- CONFIRM: valid with wake=1 → run+1; when run reaches CONFIRM_N go HOLD. Valid with wake=0 → run=0, go IDLE. No valid → hold state and run.
- HOLD: wake_o=1; timer counts HOLD_CYCLES, then COOLDOWN (or IDLE if COOLDOWN_CYCLES==0). Decisions ignored.
- COOLDOWN: timer counts COOLDOWN_CYCLES, then IDLE. Decisions ignored.
- Fire = transition into HOLD: sets irq_o and increments wake_count_o.
- decision_count_o increments on every valid while ctl_pipeline_en_i=1, in any state.
- Counters saturate at 2^COUNT_BW-1; no wrap.
- clear_i: irq_o←0, both counters←0. Fire in the same cycle wins over the clear: irq_o=1 and wake_count_o=1. A valid in the same cycle gives decision_count_o=1.
- ctl_pipeline_en_i low: next state IDLE, run and timer zeroed, wake_o drops next cycle, counters hold, irq_o holds; valids ignored. An in-progress HOLD is truncated.
- Run counter width clog2(CONFIRM_N+1); timer width clog2(max(HOLD_CYCLES,COOLDOWN_CYCLES)+1).

## Timing
- All outputs registered. Reset values: wake_o=0, irq_o=0, busy_o=0, counters=0, state IDLE.
- Latency: the completing valid at cycle t gives wake_o=irq_o=busy_o=1 at t+1.
- wake_o high exactly HOLD_CYCLES cycles (t+1 to t+HOLD_CYCLES).
- busy_o is high from t+1 through t+HOLD_CYCLES+COOLDOWN_CYCLES.
- The first decision acted on in IDLE is at t+HOLD_CYCLES+COOLDOWN_CYCLES+1.
- Reset mid-operation: all state returns to reset values on the next edge, including counters and irq_o.
- Back-to-back valids on consecutive cycles are legal.

## Configuration
- WAKE_IRQ_STATS_EN defined: both statistics counters and their saturation logic are built.
- WAKE_IRQ_STATS_EN undefined: wake_count_o and decision_count_o are tied to 0. clear_i then affects only irq_o. All other behaviour is identical.

## Structure
- Shared package wake_pkg: state encoding (IDLE=0, CONFIRM=1, HOLD=2, COOLDOWN=3), default parameter constants, COUNT_BW default.
- One sub-module, wake_sat_counter: parameterised saturating counter with clear and increment, clear-then-increment priority. Instantiated twice, under WAKE_IRQ_STATS_EN.
- Top contains the FSM, run counter, timer and irq_o register.

## Test plan
- Defaults, valids with wake=1 at cycles 10 and 20 → wake_o high at cycles 21–36, irq_o=1 from 21, wake_count_o=1, decision_count_o=2, busy_o low at cycle 101.
- Valids with wake 1, 0, 1, 1 → exactly one fire, on the fourth valid. decision_count_o=4.
- Fire, then six valid=1 during HOLD/COOLDOWN, then two more after COOLDOWN → wake_count_o=2 and decision_count_o=10. No fire occurs during busy.
- clear_i asserted in the same cycle as a completing valid → irq_o=1 and wake_count_o=1 next cycle. clear_i alone later → irq_o=0 and counters=0.
- ctl_pipeline_en_i dropped at HOLD cycle 5 → wake_o=0 next cycle, state IDLE, irq_o stays 1. Valids while disabled do not change decision_count_o.
- COUNT_BW=2, 5 fires with HOLD_CYCLES=1 and COOLDOWN_CYCLES=0 → wake_count_o saturates at 3. Separately, rst_i mid-HOLD → all outputs 0 next cycle.
